eeg_load_ctrl: RTL and testbench
================================

Name: eeg_load_ctrl

Overview:
Epoch-level sequencer between the SoC-side EEG interface and the centralized inference core. It accepts streamed ADC samples after a load request and writes them into the input memory at consecutive addresses. On the sleep-epoch tick it launches inference and returns a single-cycle inference_complete pulse to the SoC when the core finishes. It owns the load/infer ordering so the compute core never sees a partially loaded epoch.

Parameters:
NUM_SAMPLES, 3000, EEG samples per epoch; must be at least 2.
BASE_ADDR, 0, first input-memory address for sample 0.
ADDR_W, 16, input-memory address width.
DATA_W, 16, sample width; equals the AdcData_t width.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_eeg_load  in  1  pulse; arms a new epoch load
new_eeg_data  in  1  pulse; eeg is valid this cycle
eeg  in  DATA_W  AdcData_t, unsigned offset-binary sample
new_sleep_epoch  in  1  pulse; epoch boundary, request inference
mem_wr_en  out  1  input-memory write strobe
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  DATA_W  two's-complement sample (eeg with MSB inverted)
inf_start  out  1  one-cycle start pulse to the compute core
inf_done  in  1  pulse from the compute core; inference finished
inference_complete  out  1  one-cycle pulse to the SoC
busy  out  1  high in every state except IDLE
err_short_epoch  out  1  sticky; epoch tick arrived before NUM_SAMPLES were loaded
err_overflow  out  1  sticky; sample arrived when not LOADING

Behaviour:
- Reset is asynchronous. It drives all outputs to 0, the state to IDLE and the sample counter cnt to 0.
- States: IDLE, LOADING, READY, START, INFER.
- IDLE:
  - start_eeg_load -> LOADING, cnt=0, both error flags cleared.
  - new_eeg_data in IDLE sets err_overflow; the sample is dropped.
- LOADING, on each new_eeg_data:
  - Registered write one cycle later: mem_wr_en=1, mem_wr_addr=BASE_ADDR+cnt, mem_wr_data={~eeg[DATA_W-1], eeg[DATA_W-2:0]}.
  - cnt increments. cnt width is $clog2(NUM_SAMPLES+1). The address sum is truncated to ADDR_W.
  - When the sample with cnt==NUM_SAMPLES-1 is accepted, the next state is READY.
- new_sleep_epoch in LOADING:
  - If it coincides with the final sample, it is honoured: the sample is written and the next state is START.
  - Otherwise it sets err_short_epoch, stays in LOADING and keeps cnt.
- READY:
  - new_sleep_epoch -> START.
  - new_eeg_data sets err_overflow and is dropped.
- START: inf_start=1 for exactly one cycle, then -> INFER.
- INFER:
  - inf_done -> inference_complete=1 for exactly one cycle (the cycle after inf_done), state -> IDLE.
  - new_eeg_data sets err_overflow.
  - new_sleep_epoch is ignored.
  - inf_done in any other state is ignored.
- start_eeg_load outside IDLE is ignored.
- When start_eeg_load and new_eeg_data coincide in IDLE, the load is armed and that sample is dropped without setting err_overflow.
- Latency:
  - Sample in -> memory write: 1 cycle.
  - Epoch tick in READY -> inf_start: 1 cycle.
  - inf_done -> inference_complete: 1 cycle.
- mem_wr_en is never asserted outside the cycle after an accepted sample.
- Back-to-back new_eeg_data on consecutive cycles is supported; each produces a write.

Optional Feature:
Macro EEG_SUM_EN.
- Defined:
  - Adds output eeg_sum [DATA_W+$clog2(NUM_SAMPLES)-1:0], a signed sum of all converted samples of the current epoch.
  - eeg_sum is cleared on start_eeg_load acceptance and accumulates in the same cycle as each write.
  - It is stable from READY through INFER, for downstream mean removal.
- Undefined: the port and accumulator are absent and all other behaviour is identical.

Test Plan:
- Reset mid-LOADING at cnt=1500 -> all outputs 0 immediately, state IDLE. A fresh load then writes sample 0 at BASE_ADDR.
- NUM_SAMPLES=4, BASE_ADDR=0x10. Sequence: start, samples 0x8000, 0x0000, 0xFFFF, 0x7FFF, then epoch tick.
  - Required writes: addr 0x10..0x13 with data 0x0000, 0x8000, 0x7FFF, 0xFFFF.
  - inf_start one cycle after the tick; inf_done -> inference_complete the next cycle, then busy=0.
- Epoch tick after 2 of 4 samples -> err_short_epoch=1, no inf_start. Two more samples -> READY; the next tick starts inference.
- Final sample and new_sleep_epoch in the same cycle -> write issued, then inf_start the following cycle, no error flags.
- Fifth sample while READY -> err_overflow=1, no mem_wr_en. start_eeg_load during INFER is ignored (busy stays 1).
- With EEG_SUM_EN defined, samples 0x8001, 0x8002, 0x7FFF, 0x8000 -> eeg_sum=2 in READY. Without the macro the build elaborates with no eeg_sum port.

Source files
------------

// File: rtl/eeg_load_ctrl_if.sv
// eeg_load_ctrl_if: SoC-side EEG stream, input-memory write port and
// compute-core handshake of the epoch load sequencer.
// Optional macro EEG_SUM_EN adds the eeg_sum epoch accumulator output.
interface eeg_load_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
`ifdef EEG_SUM_EN
    , parameter int unsigned SUM_W = 28
`endif
);
    logic              start_eeg_load;
    logic              new_eeg_data;
    logic [DATA_W-1:0] eeg;
    logic              new_sleep_epoch;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              inf_start;
    logic              inf_done;
    logic              inference_complete;
    logic              busy;
    logic              err_short_epoch;
    logic              err_overflow;
`ifdef EEG_SUM_EN
    logic signed [SUM_W-1:0] eeg_sum;
`endif

    // Sequencer side
    modport slave (
        input  start_eeg_load, new_eeg_data, eeg, new_sleep_epoch, inf_done,
        output mem_wr_en, mem_wr_addr, mem_wr_data, inf_start,
        output inference_complete, busy, err_short_epoch, err_overflow
`ifdef EEG_SUM_EN
        , output eeg_sum
`endif
    );

    // SoC / core / testbench side
    modport master (
        output start_eeg_load, new_eeg_data, eeg, new_sleep_epoch, inf_done,
        input  mem_wr_en, mem_wr_addr, mem_wr_data, inf_start,
        input  inference_complete, busy, err_short_epoch, err_overflow
`ifdef EEG_SUM_EN
        , input eeg_sum
`endif
    );
endinterface

// File: rtl/eeg_load_ctrl.sv
// eeg_load_ctrl: epoch-level sequencer. Loads NUM_SAMPLES streamed ADC
// samples into input memory (offset-binary -> two's complement), then on
// the sleep-epoch tick launches inference and reports completion.
// Optional macro EEG_SUM_EN adds a signed running sum of the epoch samples.
module eeg_load_ctrl #(
    parameter int unsigned NUM_SAMPLES = 3000,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    eeg_load_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
`ifdef EEG_SUM_EN
    localparam int unsigned SUM_W = DATA_W + $clog2(NUM_SAMPLES);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADING,
        S_READY,
        S_START,
        S_INFER
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wr_en;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_inf_start;
    logic               r_inf_cmpl;
    logic               r_busy;
    logic               r_err_short;
    logic               r_err_ovf;

    logic [DATA_W-1:0]  w_conv;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last;

    // Offset-binary to two's complement is a flip of the sign bit
    assign w_conv = {~bus.eeg[DATA_W-1], bus.eeg[DATA_W-2:0]};
    assign w_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt);
    assign w_last = (r_cnt == LAST_CNT);

`ifdef EEG_SUM_EN
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] w_sum_inc;

    assign w_sum_inc = {{(SUM_W - DATA_W){w_conv[DATA_W-1]}}, w_conv};
    assign bus.eeg_sum = r_sum;
`endif

    // Load/infer sequencing with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_inf_start <= 1'b0;
            r_inf_cmpl  <= 1'b0;
            r_busy      <= 1'b0;
            r_err_short <= 1'b0;
            r_err_ovf   <= 1'b0;
`ifdef EEG_SUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_wr_en     <= 1'b0;
            r_inf_start <= 1'b0;
            r_inf_cmpl  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_eeg_load) begin
                        r_state     <= S_LOADING;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_err_short <= 1'b0;
                        r_err_ovf   <= 1'b0;
`ifdef EEG_SUM_EN
                        r_sum       <= '0;
`endif
                    end else if (bus.new_eeg_data) begin
                        r_err_ovf <= 1'b1;
                    end
                end
                S_LOADING: begin
                    if (bus.new_eeg_data) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_addr;
                        r_wr_data <= w_conv;
                        r_cnt     <= r_cnt + CNT_W'(1);
`ifdef EEG_SUM_EN
                        r_sum     <= r_sum + w_sum_inc;
`endif
                        if (w_last) begin
                            // A tick on the final sample is honoured directly
                            if (bus.new_sleep_epoch) begin
                                r_state     <= S_START;
                                r_inf_start <= 1'b1;
                            end else begin
                                r_state <= S_READY;
                            end
                        end else if (bus.new_sleep_epoch) begin
                            r_err_short <= 1'b1;
                        end
                    end else if (bus.new_sleep_epoch) begin
                        r_err_short <= 1'b1;
                    end
                end
                S_READY: begin
                    if (bus.new_sleep_epoch) begin
                        r_state     <= S_START;
                        r_inf_start <= 1'b1;
                    end
                    if (bus.new_eeg_data) begin
                        r_err_ovf <= 1'b1;
                    end
                end
                S_START: begin
                    r_state <= S_INFER;
                    if (bus.new_eeg_data) begin
                        r_err_ovf <= 1'b1;
                    end
                end
                S_INFER: begin
                    if (bus.inf_done) begin
                        r_state    <= S_IDLE;
                        r_inf_cmpl <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                    if (bus.new_eeg_data) begin
                        r_err_ovf <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_wr_en          = r_wr_en;
    assign bus.mem_wr_addr        = r_wr_addr;
    assign bus.mem_wr_data        = r_wr_data;
    assign bus.inf_start          = r_inf_start;
    assign bus.inference_complete = r_inf_cmpl;
    assign bus.busy               = r_busy;
    assign bus.err_short_epoch    = r_err_short;
    assign bus.err_overflow       = r_err_ovf;
endmodule

// File: tb/tb_eeg_load_ctrl.sv
// tb_eeg_load_ctrl: scoreboard bench. The driver feeds an epoch-level
// reference model that queues expected writes, start/complete pulses and
// per-cycle status; an independent negedge monitor pops and compares.
module tb_eeg_load_ctrl;
    localparam int unsigned N    = 4;
    localparam int unsigned BASE = 32'h10;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    eeg_load_ctrl_if #(
        .ADDR_W(AW), .DATA_W(DW)
`ifdef EEG_SUM_EN
        , .SUM_W(DW + $clog2(N))
`endif
    ) bus ();

    eeg_load_ctrl #(
        .NUM_SAMPLES(N), .BASE_ADDR(BASE), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int     cyc;
        logic   busy;
        logic   shrt;
        logic   ovf;
        longint sum;
    } st_t;

    wr_t wq[$];
    st_t stq[$];
    int  startq[$];
    int  cmplq[$];

    int cyc    = 0;
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string nm, input string act, input string exp);
        checks++;
        errors++;
        $display("FAIL %s: actual=%s required=%s (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    // Epoch phases: idle, collecting samples, full and waiting for the tick,
    // start pulse cycle, waiting for the core.
    localparam int P_IDLE = 0, P_COLLECT = 1, P_FULL = 2, P_LAUNCH = 3, P_WAIT = 4;
    int     m_phase = P_IDLE;
    int     m_loaded = 0;
    bit     m_short = 0;
    bit     m_ovf = 0;
    longint m_sum = 0;

    task automatic model(input bit s, input bit dv, input logic [DW-1:0] d,
                         input bit t, input bit dn);
        int tc;
        logic [DW-1:0] conv;
        logic [DW-1:0] flip;
        tc   = cyc + 1;
        flip = 16'h8000;
        conv = d ^ flip;
        // Samples outside collection are flagged, except the one riding on the arm request
        if (dv && m_phase != P_COLLECT && !(m_phase == P_IDLE && s)) m_ovf = 1;
        case (m_phase)
            P_IDLE: if (s) begin
                m_phase = P_COLLECT; m_loaded = 0; m_short = 0; m_ovf = 0; m_sum = 0;
            end
            P_COLLECT: begin
                if (dv) begin
                    wq.push_back('{tc, AW'(BASE + m_loaded), conv});
                    m_sum += longint'($signed(conv));
                    m_loaded++;
                end
                if (m_loaded == N && dv) begin
                    if (t) begin m_phase = P_LAUNCH; startq.push_back(tc); end
                    else m_phase = P_FULL;
                end else if (t) m_short = 1;
            end
            P_FULL: if (t) begin m_phase = P_LAUNCH; startq.push_back(tc); end
            P_LAUNCH: m_phase = P_WAIT;
            P_WAIT: if (dn) begin m_phase = P_IDLE; cmplq.push_back(tc); end
            default: m_phase = P_IDLE;
        endcase
        stq.push_back('{tc, m_phase != P_IDLE, m_short, m_ovf, m_sum});
    endtask

    task automatic step(input bit s, input bit dv, input logic [DW-1:0] d,
                        input bit t, input bit dn);
        @(posedge clk);
        #1;
        bus.start_eeg_load  = s;
        bus.new_eeg_data    = dv;
        bus.eeg             = d;
        bus.new_sleep_epoch = t;
        bus.inf_done        = dn;
        model(s, dv, d, t, dn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
        chk({tag, "_wr_en"}, 64'(bus.mem_wr_en), 0);
        chk({tag, "_wr_addr"}, 64'(bus.mem_wr_addr), 0);
        chk({tag, "_wr_data"}, 64'(bus.mem_wr_data), 0);
        chk({tag, "_inf_start"}, 64'(bus.inf_start), 0);
        chk({tag, "_cmpl"}, 64'(bus.inference_complete), 0);
        chk({tag, "_short"}, 64'(bus.err_short_epoch), 0);
        chk({tag, "_ovf"}, 64'(bus.err_overflow), 0);
`ifdef EEG_SUM_EN
        chk({tag, "_sum"}, 64'(bus.eeg_sum), 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        bus.start_eeg_load = 0; bus.new_eeg_data = 0; bus.eeg = '0;
        bus.new_sleep_epoch = 0; bus.inf_done = 0;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        wq.delete(); stq.delete(); startq.delete(); cmplq.delete();
        m_phase = P_IDLE; m_loaded = 0; m_short = 0; m_ovf = 0; m_sum = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    wr_t mw;
    st_t ms;
    int  mc;

    // Compare DUT outputs against queued expectations, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                mw = wq.pop_front();
                note_fail("wr_missing", "no write", $sformatf("write addr 0x%0h", mw.addr));
            end
            if (bus.mem_wr_en) begin
                if (wq.size() == 0) begin
                    note_fail("wr_unexpected", $sformatf("write addr 0x%0h", bus.mem_wr_addr), "no write");
                end else begin
                    mw = wq.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(mw.cyc));
                    chk("wr_addr", 64'(bus.mem_wr_addr), 64'(mw.addr));
                    chk("wr_data", 64'(bus.mem_wr_data), 64'(mw.data));
                end
            end
            while (startq.size() > 0 && startq[0] < cyc) begin
                mc = startq.pop_front();
                note_fail("inf_start_missing", "0", $sformatf("1 at cycle %0d", mc));
            end
            if (bus.inf_start) begin
                if (startq.size() == 0) note_fail("inf_start_unexpected", "1", "0");
                else begin
                    mc = startq.pop_front();
                    chk("inf_start_cycle", 64'(cyc), 64'(mc));
                end
            end
            while (cmplq.size() > 0 && cmplq[0] < cyc) begin
                mc = cmplq.pop_front();
                note_fail("cmpl_missing", "0", $sformatf("1 at cycle %0d", mc));
            end
            if (bus.inference_complete) begin
                if (cmplq.size() == 0) note_fail("cmpl_unexpected", "1", "0");
                else begin
                    mc = cmplq.pop_front();
                    chk("cmpl_cycle", 64'(cyc), 64'(mc));
                end
            end
            while (stq.size() > 0 && stq[0].cyc < cyc) void'(stq.pop_front());
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                ms = stq.pop_front();
                chk("busy", 64'(bus.busy), 64'(ms.busy));
                chk("err_short_epoch", 64'(bus.err_short_epoch), 64'(ms.shrt));
                chk("err_overflow", 64'(bus.err_overflow), 64'(ms.ovf));
`ifdef EEG_SUM_EN
                chk("eeg_sum", 64'($signed(bus.eeg_sum)), 64'(ms.sum));
`endif
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.start_eeg_load = 0; bus.new_eeg_data = 0; bus.eeg = '0;
        bus.new_sleep_epoch = 0; bus.inf_done = 0;
        #2 rst_n = 1'b0;
        #1 check_zero("por");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Nominal epoch: conversion edge values, then launch and complete
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h8000, 0, 0);
        step(0, 1, 16'h0000, 0, 0);
        step(0, 1, 16'hFFFF, 0, 0);
        step(0, 1, 16'h7FFF, 0, 0);
        idle(2);
        step(0, 0, '0, 1, 0);
        idle(3);
        step(0, 0, '0, 0, 1);
        idle(2);

        // Early tick flags a short epoch and does not launch
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h1234, 0, 0);
        step(0, 1, 16'hABCD, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(1);
        step(0, 1, 16'h0F0F, 0, 0);
        step(0, 1, 16'hF0F0, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(2);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Final sample coincident with the tick
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h0001, 0, 0);
        step(0, 1, 16'h0002, 0, 0);
        step(0, 1, 16'h0003, 0, 0);
        step(0, 1, 16'h0004, 1, 0);
        idle(2);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Extra sample while full, start request during inference
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h4000 + i), 0, 0);
        step(0, 1, 16'h5555, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(1);
        step(1, 0, '0, 0, 0);
        idle(1);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Arm with a coincident sample (dropped, no flag), then sum check
        step(1, 1, 16'h9999, 0, 0);
        step(0, 1, 16'h8001, 0, 0);
        step(0, 1, 16'h8002, 0, 0);
        step(0, 1, 16'h7FFF, 0, 0);
        step(0, 1, 16'h8000, 0, 0);
        idle(1);
`ifdef EEG_SUM_EN
        @(negedge clk);
        chk("eeg_sum_ready", 64'($signed(bus.eeg_sum)), 64'd2);
`endif
        step(0, 0, '0, 1, 0);
        idle(2);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Reset in the middle of a load, then a fresh load from BASE
        step(1, 0, '0, 0, 0);
        step(0, 1, 16'h1111, 0, 0);
        step(0, 1, 16'h2222, 0, 0);
        do_reset("midload");
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 16'(16'hC000 + i), 0, 0);
        step(0, 0, '0, 1, 0);
        idle(2);
        step(0, 0, '0, 0, 1);
        idle(1);

        // Random traffic, including inputs in every phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) == 0, ($urandom % 2) == 0, 16'($urandom),
                 ($urandom % 9) == 0, ($urandom % 5) == 0);
        end
        idle(4);
        @(negedge clk);
        @(negedge clk);
        chk("wq_drained", 64'(wq.size()), 0);
        chk("startq_drained", 64'(startq.size()), 0);
        chk("cmplq_drained", 64'(cmplq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
